// File: rtl/mem_pkg.sv
// Shared definitions for the multi-cycle SRAM memory stage.
package mem_pkg;

    // Access sequencer states: wait for a request, low halfword, high halfword, hand back.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Byte address that maps to SRAM word 0.
    localparam int unsigned BASE_ADDR_DEF = 1024;

    // External SRAM geometry: 18-bit halfword address, 16-bit data.
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    // Word index width: one halfword-select bit below it makes up the SRAM address.
    localparam int IDX_W = SRAM_AW - 1;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts cycles spent on one halfword and flags the last one.
module sram_wait_counter #(
    parameter int SRAM_WAIT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    // A single-cycle phase still needs a 1-bit counter so the ports stay legal.
    localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(SRAM_WAIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over enable so a phase boundary always restarts at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory stage controller: splits a 32-bit word access into two 16-bit SRAM
// cycles and holds the pipeline frozen (ready=0) until the word is done.
module mem_sram_ctrl
    import mem_pkg::*;
#(
    parameter int          SRAM_WAIT = 2,
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]   sram_dq_out,
    input  logic [SRAM_DW-1:0]   sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n
);

    state_t state_q, state_d;

    // Values latched at request time so a request dropped mid-access still completes.
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;

    // Captured read halves and the completed load word.
    logic [SRAM_DW-1:0] lo_q, lo_d;
    logic [SRAM_DW-1:0] hi_q, hi_d;
    logic [31:0]        read_data_q, read_data_d;

    // Registered SRAM pins, computed one cycle ahead from the next state.
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0] sram_dq_out_q, sram_dq_out_d;
    logic               sram_dq_oe_q, sram_dq_oe_d;
    logic               sram_we_n_q, sram_we_n_d;

    logic               req;
    logic [31:0]        offset;
    logic [IDX_W-1:0]   idx_in;
    logic               wait_clr, wait_en, wait_last;

    assign req    = rd_en | wr_en;
    // Out-of-window addresses wrap: the index is simply truncated.
    assign offset = address - 32'(BASE_ADDR);
    assign idx_in = IDX_W'(offset >> 2);

    sram_wait_counter #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_wait (
        .clock  (clock),
        .reset  (reset),
        .clear  (wait_clr),
        .enable (wait_en),
        .last   (wait_last)
    );

    // Next-state, latch and SRAM pin logic; pins are set up for the state being entered.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        wr_d          = wr_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        read_data_d   = read_data_q;
        sram_addr_d   = sram_addr_q;
        sram_dq_out_d = sram_dq_out_q;
        sram_dq_oe_d  = sram_dq_oe_q;
        sram_we_n_d   = sram_we_n_q;
        wait_clr      = 1'b0;
        wait_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d     = LO;
                    idx_d       = idx_in;
                    wdata_d     = write_data;
                    wr_d        = wr_en;          // write wins when both enables are set
                    wait_clr    = 1'b1;
                    sram_addr_d = {idx_in, 1'b0};
                    if (wr_en) begin
                        sram_dq_out_d = write_data[15:0];
                        sram_dq_oe_d  = 1'b1;
                        sram_we_n_d   = 1'b0;
                    end else begin
                        sram_dq_oe_d  = 1'b0;
                        sram_we_n_d   = 1'b1;
                    end
                end
            end
            LO: begin
                if (wait_last) begin
                    state_d     = HI;
                    wait_clr    = 1'b1;
                    sram_addr_d = {idx_q, 1'b1};
                    if (wr_q) begin
                        sram_dq_out_d = wdata_q[31:16];
                    end else begin
                        lo_d = sram_dq_in;
                    end
                end else begin
                    wait_en = 1'b1;
                end
            end
            HI: begin
                if (wait_last) begin
                    state_d      = DONE;
                    wait_clr     = 1'b1;
                    sram_dq_oe_d = 1'b0;
                    sram_we_n_d  = 1'b1;
                    if (!wr_q) begin
                        hi_d = sram_dq_in;
                    end
                end else begin
                    wait_en = 1'b1;
                end
            end
            DONE: begin
                // Always pass through IDLE so a request held by the frozen pipeline is not replayed.
                state_d = IDLE;
                if (!wr_q) begin
                    read_data_d = {hi_q, lo_q};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset releases the bus and deasserts the strobe at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            lo_q          <= '0;
            hi_q          <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wdata_q       <= wdata_d;
            wr_q          <= wr_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            read_data_q   <= read_data_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            sram_we_n_q   <= sram_we_n_d;
        end
    end

    // Stall while an access is pending or in flight; release only in DONE or a quiet IDLE.
    always_comb begin
        ready = 1'b0;
        if (state_q == DONE) begin
            ready = 1'b1;
        end else if (state_q == IDLE && !req) begin
            ready = 1'b1;
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: instance 0 uses SRAM_WAIT=2, instance 1 uses SRAM_WAIT=1.
// Stimulus pushes the expected access into a per-instance queue; the monitor pops
// it when the access starts and checks the SRAM trace, stall length and result.
module tb_mem_sram_ctrl;

    typedef struct {
        logic        wr;
        logic [17:0] a_lo;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gap;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rd_en      [2];
    logic        wr_en      [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic        ready      [2];
    logic [17:0] sram_addr  [2];
    logic [15:0] dq_out     [2];
    logic [15:0] dq_in      [2];
    logic        oe         [2];
    logic        we_n       [2];

    logic [15:0] mem [2][64];

    exp_t exp_q [2][$];
    exp_t cur   [2];
    int   run       [2];
    int   last_done [2];
    logic chk_rd    [2];
    int   cyc;
    int   checks;
    int   errors;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_sram_ctrl #(
            .SRAM_WAIT ((g == 0) ? 2 : 1),
            .BASE_ADDR (1024)
        ) u_dut (
            .clock       (clock),
            .reset       (reset),
            .rd_en       (rd_en[g]),
            .wr_en       (wr_en[g]),
            .address     (address[g]),
            .write_data  (write_data[g]),
            .read_data   (read_data[g]),
            .ready       (ready[g]),
            .sram_addr   (sram_addr[g]),
            .sram_dq_out (dq_out[g]),
            .sram_dq_in  (dq_in[g]),
            .sram_dq_oe  (oe[g]),
            .sram_we_n   (we_n[g])
        );
        assign dq_in[g] = mem[g][sram_addr[g][5:0]];
    end

    // SRAM model: asynchronous read, write sampled at each clock edge while the strobe is low.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (!we_n[k]) mem[k][sram_addr[k][5:0]] <= dq_out[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // Monitor: observes both instances at every falling edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            run[k] = 0; last_done[k] = 0; chk_rd[k] = 1'b0;
        end
        cyc = 0;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    run[k] = 0;
                    chk_rd[k] = 1'b0;
                end else begin
                    if (chk_rd[k]) begin
                        chk($sformatf("rdata%0d", k), read_data[k], cur[k].rd);
                        chk_rd[k] = 1'b0;
                    end
                    if (!ready[k]) begin
                        if (run[k] == 0) begin
                            if (exp_q[k].size() == 0) begin
                                checks++; errors++;
                                $display("FAIL unexpected_access%0d actual=stall expected=idle", k);
                            end else begin
                                cur[k] = exp_q[k].pop_front();
                            end
                            chk($sformatf("idle_bus%0d", k), {30'd0, we_n[k], oe[k]}, 32'd2);
                        end else if (run[k] <= 2 * wait_of(k)) begin
                            if (run[k] > wait_of(k)) begin
                                chk($sformatf("addr_hi%0d", k), 32'(sram_addr[k]), 32'({cur[k].a_lo[17:1], 1'b1}));
                                if (cur[k].wr) chk($sformatf("dq_hi%0d", k), 32'(dq_out[k]), 32'(cur[k].wd[31:16]));
                            end else begin
                                chk($sformatf("addr_lo%0d", k), 32'(sram_addr[k]), 32'({cur[k].a_lo[17:1], 1'b0}));
                                if (cur[k].wr) chk($sformatf("dq_lo%0d", k), 32'(dq_out[k]), 32'(cur[k].wd[15:0]));
                            end
                            chk($sformatf("strobe%0d", k), {30'd0, we_n[k], oe[k]}, {30'd0, ~cur[k].wr, cur[k].wr});
                        end
                        run[k]++;
                    end else if (run[k] > 0) begin
                        chk($sformatf("stall_len%0d", k), run[k], 2 * wait_of(k) + 1);
                        chk($sformatf("done_bus%0d", k), {30'd0, we_n[k], oe[k]}, 32'd2);
                        if (cur[k].gap != 0) chk($sformatf("gap%0d", k), cyc - last_done[k], cur[k].gap);
                        last_done[k] = cyc;
                        chk_rd[k] = 1'b1;
                        run[k] = 0;
                    end
                end
            end
            cyc++;
        end
    end

    // Issue one access on instance k and wait (bounded) for ready; optionally keep the request up.
    task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [17:0] a_lo,
                          input logic [31:0] exp_rd, input int gap, input bit hold);
        exp_t e;
        int   n;
        @(posedge clock); #1;
        e.wr = wr; e.a_lo = a_lo; e.wd = wd; e.rd = exp_rd; e.gap = gap;
        exp_q[k].push_back(e);
        rd_en[k] = rd; wr_en[k] = wr; address[k] = addr; write_data[k] = wd;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ready[k] && n < 50);
        if (!ready[k]) begin
            checks++; errors++;
            $display("FAIL timeout%0d actual=ready_low expected=ready_high", k);
        end
        if (!hold) begin
            @(posedge clock); #1;
            rd_en[k] = 1'b0; wr_en[k] = 1'b0;
            repeat (2) @(posedge clock);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd_en[k] = 1'b0; wr_en[k] = 1'b0; address[k] = '0; write_data[k] = '0;
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset values with no request pending.
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready%0d", k), 32'(ready[k]), 32'd1);
            chk($sformatf("rst_bus%0d", k), {30'd0, we_n[k], oe[k]}, 32'd2);
            chk($sformatf("rst_rdata%0d", k), read_data[k], 32'd0);
            chk($sformatf("rst_addr%0d", k), 32'(sram_addr[k]), 32'd0);
            chk($sformatf("rst_dq%0d", k), 32'(dq_out[k]), 32'd0);
        end

        // SRAM_WAIT=2: store, load back, both-enables store, wrap-around address.
        access(0, 0, 1, 32'd1028, 32'hDEADBEEF, 18'd2,       32'h0,        0, 0);
        access(0, 1, 0, 32'd1028, 32'h0,       18'd2,       32'hDEADBEEF, 0, 0);
        access(0, 1, 1, 32'd1032, 32'h12345678, 18'd4,      32'hDEADBEEF, 0, 0);
        access(0, 1, 0, 32'd1032, 32'h0,       18'd4,       32'h12345678, 0, 0);
        access(0, 0, 1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE,  32'h12345678, 0, 0);
        access(0, 1, 0, 32'd1020, 32'h0,       18'h3FFFE,   32'hCAFEF00D, 0, 0);

        // Reset asserted in the HI phase of a store.
        @(posedge clock); #1;
        exp_q[0].push_back('{wr: 1'b1, a_lo: 18'd6, wd: 32'h0BADF00D, rd: 32'h0, gap: 0});
        wr_en[0] = 1'b1; address[0] = 32'd1036; write_data[0] = 32'h0BADF00D;
        repeat (3) @(posedge clock);
        #3;
        chk("hi_phase_addr", 32'(sram_addr[0]), 32'd7);
        reset = 1'b1;
        #1;
        chk("arst_bus", {30'd0, we_n[0], oe[0]}, 32'd2);
        chk("arst_addr", 32'(sram_addr[0]), 32'd0);
        chk("arst_ready_req", 32'(ready[0]), 32'd0);
        chk("arst_rdata", read_data[0], 32'd0);
        wr_en[0] = 1'b0;
        #1;
        chk("arst_ready_idle", 32'(ready[0]), 32'd1);
        @(posedge clock); #1 reset = 1'b0;
        repeat (2) @(posedge clock);

        // SRAM_WAIT=1: two stores, then back-to-back loads 4 cycles apart.
        access(1, 0, 1, 32'd1024, 32'h11112222, 18'd0, 32'h0,        0, 0);
        access(1, 0, 1, 32'd1028, 32'h33334444, 18'd2, 32'h0,        0, 0);
        access(1, 1, 0, 32'd1024, 32'h0,        18'd0, 32'h11112222, 0, 1);
        access(1, 1, 0, 32'd1028, 32'h0,        18'd2, 32'h33334444, 4, 0);

        repeat (3) @(negedge clock);
        chk("drain", exp_q[0].size() + exp_q[1].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
